// File: rtl/syzygy_dac_pkg.sv
// Shared types and constants for the SYZYGY DAC stream player.
// DAC_OFFSET_BINARY_EN selects offset-binary output coding (MSB inverted, idle code 16'h8000).
package syzygy_dac_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        PLAY    = 2'd2,
        FLUSH   = 2'd3
    } state_e;

    // One buffered stream beat: sample pair plus end-of-frame marker
    typedef struct packed {
        logic                last;
        logic [SAMPLE_W-1:0] ch2;
        logic [SAMPLE_W-1:0] ch1;
    } fifo_word_t;

`ifdef DAC_OFFSET_BINARY_EN
    localparam logic [SAMPLE_W-1:0] MSB_FLIP  = SAMPLE_W'(16'h8000);
`else
    localparam logic [SAMPLE_W-1:0] MSB_FLIP  = SAMPLE_W'(16'h0000);
`endif
    localparam logic [SAMPLE_W-1:0] IDLE_CODE = MSB_FLIP;

    function automatic logic [SAMPLE_W-1:0] to_dac_code(input logic [SAMPLE_W-1:0] s);
        return s ^ MSB_FLIP;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and synchronous clear.
module sync_fifo #(
    parameter  int unsigned WIDTH = 33,
    parameter  int unsigned DEPTH = 512,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_c_o,
    output logic             full_c_o,
    output logic             empty_c_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign full_c_o    = (count_q == CW'(DEPTH));
    assign empty_c_o   = (count_q == '0);
    assign rd_data_c_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle
    assign do_rd = rd_en_i && !empty_c_o && !clr_i;
    assign do_wr = wr_en_i && (!full_c_o || do_rd) && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_wr && !do_rd)      count_d = count_q + CW'(1);
            else if (!do_wr && do_rd) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/syzygy_dac_stream_player.sv
// AXI-Stream to two-channel DAC playback engine with prefill, underflow and frame tracking.
// DAC_OFFSET_BINARY_EN (see syzygy_dac_pkg) switches the output coding to offset binary.
module syzygy_dac_stream_player
    import syzygy_dac_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 512,
    parameter int unsigned PREFILL_WORDS = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    input  logic                sample_en,
    input  logic                start,
    input  logic                stop,
    output logic [SAMPLE_W-1:0] dac_data_1,
    output logic [SAMPLE_W-1:0] dac_data_2,
    output logic                dac_valid,
    output logic                playing,
    output logic                underflow,
    output logic                frame_done,
    output logic [31:0]         words_played
);

    localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WORD_W = $bits(fifo_word_t);

    state_e              state_q, state_d;
    logic [2:0]          start_sync_q, stop_sync_q;
    logic                tlast_seen_q, tlast_seen_d;
    logic [SAMPLE_W-1:0] data1_q, data1_d, data2_q, data2_d;
    logic                valid_q, valid_d;
    logic                playing_q;
    logic                underflow_q, underflow_d;
    logic                done_q, done_d;
    logic [31:0]         words_q, words_d;

    logic                start_edge, stop_edge, accept, accept_last;
    logic                fifo_clr, fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [WORD_W-1:0]   fifo_rdata_raw;
    fifo_word_t          wr_word, rd_word;

    // Bits [1:0] synchronise the GPIO levels, bit [2] is the edge-detect history
    assign start_edge  = start_sync_q[1] && !start_sync_q[2];
    assign stop_edge   = stop_sync_q[1] && !stop_sync_q[2];
    assign accept      = s_axis_tvalid && s_axis_tready;
    assign accept_last = accept && s_axis_tlast;
    assign wr_word     = '{last: s_axis_tlast, ch2: s_axis_tdata[31:16], ch1: s_axis_tdata[15:0]};
    assign rd_word     = fifo_word_t'(fifo_rdata_raw);

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset_n),
        .clr_i       (fifo_clr),
        .wr_en_i     (fifo_wr),
        .wr_data_i   (wr_word),
        .rd_en_i     (fifo_rd),
        .rd_data_c_o (fifo_rdata_raw),
        .full_c_o    (fifo_full),
        .empty_c_o   (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        s_axis_tready = 1'b0;
        case (state_q)
            PREFILL: s_axis_tready = !fifo_full;
            PLAY:    s_axis_tready = !fifo_full && !tlast_seen_q;
            FLUSH:   s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        tlast_seen_d = tlast_seen_q;
        data1_d      = (state_q == PLAY) ? data1_q : IDLE_CODE;
        data2_d      = (state_q == PLAY) ? data2_q : IDLE_CODE;
        valid_d      = 1'b0;
        done_d       = 1'b0;
        underflow_d  = underflow_q;
        words_d      = words_q;
        fifo_clr     = 1'b0;
        fifo_wr      = 1'b0;
        fifo_rd      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_edge && !stop_edge) begin
                    underflow_d  = 1'b0;
                    words_d      = '0;
                    tlast_seen_d = 1'b0;
                    fifo_clr     = 1'b1;
                    state_d      = PREFILL;
                end
            end
            PREFILL: begin
                if (stop_edge) begin
                    fifo_clr = 1'b1;
                    state_d  = (tlast_seen_q || accept_last) ? IDLE : FLUSH;
                end else begin
                    fifo_wr = accept;
                    if (accept_last) tlast_seen_d = 1'b1;
                    if (fifo_count >= CW'(PREFILL_WORDS) || accept_last) state_d = PLAY;
                end
            end
            PLAY: begin
                if (stop_edge) begin
                    fifo_clr = 1'b1;
                    data1_d  = IDLE_CODE;
                    data2_d  = IDLE_CODE;
                    state_d  = (tlast_seen_q || accept_last) ? IDLE : FLUSH;
                end else begin
                    fifo_wr = accept;
                    if (accept_last) tlast_seen_d = 1'b1;
                    if (sample_en) begin
                        if (!fifo_empty) begin
                            fifo_rd = 1'b1;
                            data1_d = to_dac_code(rd_word.ch1);
                            data2_d = to_dac_code(rd_word.ch2);
                            valid_d = 1'b1;
                            words_d = (words_q == 32'hFFFF_FFFF) ? words_q : words_q + 32'd1;
                            if (rd_word.last) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end else begin
                            underflow_d = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (accept_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            start_sync_q <= '0;
            stop_sync_q  <= '0;
            tlast_seen_q <= 1'b0;
            data1_q      <= IDLE_CODE;
            data2_q      <= IDLE_CODE;
            valid_q      <= 1'b0;
            playing_q    <= 1'b0;
            underflow_q  <= 1'b0;
            done_q       <= 1'b0;
            words_q      <= '0;
        end else begin
            state_q      <= state_d;
            start_sync_q <= {start_sync_q[1:0], start};
            stop_sync_q  <= {stop_sync_q[1:0], stop};
            tlast_seen_q <= tlast_seen_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            valid_q      <= valid_d;
            playing_q    <= (state_d == PLAY);
            underflow_q  <= underflow_d;
            done_q       <= done_d;
            words_q      <= words_d;
        end
    end

    assign dac_data_1   = data1_q;
    assign dac_data_2   = data2_q;
    assign dac_valid    = valid_q;
    assign playing      = playing_q;
    assign underflow    = underflow_q;
    assign frame_done   = done_q;
    assign words_played = words_q;

endmodule

// File: tb/tb_syzygy_dac_stream_player.sv
// Randomised self-checking bench for syzygy_dac_stream_player against a queue-based reference model.
module tb_syzygy_dac_stream_player;

    localparam int DEPTH   = 16;
    localparam int PREFILL = 4;
`ifdef DAC_OFFSET_BINARY_EN
    localparam logic [15:0] FLIP     = 16'h8000;
    localparam logic [15:0] EXP_FFFF = 16'h7FFF;
`else
    localparam logic [15:0] FLIP     = 16'h0000;
    localparam logic [15:0] EXP_FFFF = 16'hFFFF;
`endif
    localparam logic [15:0] IDLE_V = FLIP;

    localparam int M_IDLE = 0, M_PREFILL = 1, M_PLAY = 2, M_FLUSH = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic        sample_en, start, stop;
    logic [15:0] dac_data_1, dac_data_2;
    logic        dac_valid, playing, underflow, frame_done;
    logic [31:0] words_played;

    syzygy_dac_stream_player #(
        .FIFO_DEPTH    (DEPTH),
        .PREFILL_WORDS (PREFILL)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .sample_en     (sample_en),
        .start         (start),
        .stop          (stop),
        .dac_data_1    (dac_data_1),
        .dac_data_2    (dac_data_2),
        .dac_valid     (dac_valid),
        .playing       (playing),
        .underflow     (underflow),
        .frame_done    (frame_done),
        .words_played  (words_played)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: frame buffer as a queue, GPIO pins seen through a 3-sample history
    int          m_state;
    logic [32:0] m_q[$];
    bit          m_tl, m_acc;
    bit          s1, s2, s3, p1, p2, p3;
    logic [15:0] e_d1, e_d2;
    bit          e_dv, e_fd, e_play, e_uf;
    logic [31:0] e_wp;

    logic [31:0] got[$];
    int          fd_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_tready();
        case (m_state)
            M_PREFILL: return m_q.size() < DEPTH;
            M_PLAY:    return (m_q.size() < DEPTH) && !m_tl;
            M_FLUSH:   return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_q.delete(); m_tl = 0; m_acc = 0;
        s1 = 0; s2 = 0; s3 = 0; p1 = 0; p2 = 0; p3 = 0;
        e_d1 = IDLE_V; e_d2 = IDLE_V; e_dv = 0; e_fd = 0; e_play = 0; e_uf = 0; e_wp = 0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven
    task automatic model_step();
        bit st_e, sp_e, acc, tl;
        int sz;
        logic [32:0] w;
        st_e = s2 && !s3;
        sp_e = p2 && !p3;
        s3 = s2; s2 = s1; s1 = start;
        p3 = p2; p2 = p1; p1 = stop;
        acc = s_axis_tvalid && m_tready();
        tl = acc && s_axis_tlast;
        m_acc = acc;
        sz = m_q.size();
        e_dv = 0; e_fd = 0;
        if (m_state != M_PLAY) begin e_d1 = IDLE_V; e_d2 = IDLE_V; end
        case (m_state)
            M_IDLE: if (st_e && !sp_e) begin
                e_uf = 0; e_wp = 0; m_q.delete(); m_tl = 0; m_state = M_PREFILL;
            end
            M_PREFILL: if (sp_e) begin
                m_q.delete();
                m_state = (m_tl || tl) ? M_IDLE : M_FLUSH;
            end else begin
                if (acc) m_q.push_back({s_axis_tlast, s_axis_tdata});
                if (tl) m_tl = 1;
                if (sz >= PREFILL || tl) m_state = M_PLAY;
            end
            M_PLAY: if (sp_e) begin
                m_q.delete();
                e_d1 = IDLE_V; e_d2 = IDLE_V;
                m_state = (m_tl || tl) ? M_IDLE : M_FLUSH;
            end else begin
                if (sample_en) begin
                    if (sz > 0) begin
                        w = m_q.pop_front();
                        e_d1 = w[15:0] ^ FLIP;
                        e_d2 = w[31:16] ^ FLIP;
                        e_dv = 1;
                        if (e_wp != 32'hFFFF_FFFF) e_wp = e_wp + 1;
                        if (w[32]) begin e_fd = 1; m_state = M_IDLE; end
                    end else begin
                        e_uf = 1;
                    end
                end
                if (acc) m_q.push_back({s_axis_tlast, s_axis_tdata});
                if (tl) m_tl = 1;
            end
            M_FLUSH: if (tl) m_state = M_IDLE;
            default: m_state = M_IDLE;
        endcase
        e_play = (m_state == M_PLAY);
    endtask

    task automatic check();
        chk("tready", 32'(s_axis_tready), 32'(m_tready()));
        chk("dac_data_1", 32'(dac_data_1), 32'(e_d1));
        chk("dac_data_2", 32'(dac_data_2), 32'(e_d2));
        chk("dac_valid", 32'(dac_valid), 32'(e_dv));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("playing", 32'(playing), 32'(e_play));
        chk("underflow", 32'(underflow), 32'(e_uf));
        chk("words_played", words_played, e_wp);
        if (dac_valid) got.push_back({dac_data_2, dac_data_1});
        if (frame_done) fd_cnt++;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check();
    endtask

    task automatic reset_mid();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_d1", 32'(dac_data_1), 32'(IDLE_V));
        chk("rst_async_d2", 32'(dac_data_2), 32'(IDLE_V));
        chk("rst_async_valid", 32'(dac_valid), 32'd0);
        chk("rst_async_playing", 32'(playing), 32'd0);
        chk("rst_async_underflow", 32'(underflow), 32'd0);
        chk("rst_async_words", words_played, 32'd0);
        chk("rst_async_tready", 32'(s_axis_tready), 32'd0);
        model_reset();
        s_axis_tvalid = 0; s_axis_tlast = 0; sample_en = 0; start = 0; stop = 0;
        @(negedge clk);
        reset_n = 1'b1;
        check();
    endtask

    // spct < 0 gives a sample strobe every 4 cycles; pattern 0 random, 1 ascending, 2 all-ones
    task automatic run_frame(input int len, input int vpct, input int spct, input int stop_after,
                             input int stall_from, input int stall_cyc, input int rst_after,
                             input int pattern);
        logic [32:0] tx[$];
        logic [31:0] d;
        int acc_cnt, stall_cnt, stop_cnt, cyc;
        bit seen;
        got.delete(); fd_cnt = 0;
        for (int i = 0; i < len; i++) begin
            case (pattern)
                1:       d = {16'(i + 1) + 16'h0100, 16'(i + 1)};
                2:       d = 32'hFFFF_FFFF;
                default: d = $urandom;
            endcase
            tx.push_back({(i == len - 1), d});
        end
        s_axis_tvalid = 0; s_axis_tlast = 0; sample_en = 0;
        start = 1; tick(); tick(); start = 0;
        acc_cnt = 0; stall_cnt = 0; stop_cnt = 0; cyc = 0; seen = 0;
        forever begin
            s_axis_tvalid = (tx.size() > 0) && (int'($urandom_range(99)) < vpct);
            if (stall_from >= 0 && acc_cnt >= stall_from && stall_cnt < stall_cyc) begin
                s_axis_tvalid = 0;
                stall_cnt++;
            end
            if (tx.size() > 0) begin
                s_axis_tdata = tx[0][31:0];
                s_axis_tlast = s_axis_tvalid && tx[0][32];
            end else begin
                s_axis_tdata = $urandom;
                s_axis_tlast = 0;
            end
            sample_en = (spct < 0) ? (cyc % 4 == 0) : (int'($urandom_range(99)) < spct);
            stop = (stop_after >= 0) && (acc_cnt >= stop_after) && (stop_cnt < 3);
            if (stop) stop_cnt++;
            tick();
            cyc++;
            if (m_acc) begin void'(tx.pop_front()); acc_cnt++; end
            if (m_state != M_IDLE) seen = 1;
            if (rst_after >= 0 && acc_cnt >= rst_after && m_state == M_PLAY) begin
                reset_mid();
                break;
            end
            if (seen && m_state == M_IDLE && tx.size() == 0) break;
            if (cyc > 4000) begin
                n_chk++; n_err++;
                $display("FAIL frame_timeout: state %0d after %0d cycles, required return to idle", m_state, cyc);
                break;
            end
        end
        s_axis_tvalid = 0; s_axis_tlast = 0; sample_en = 0; stop = 0;
        repeat (4) tick();
    endtask

    initial begin
        reset_n = 0; s_axis_tdata = 0; s_axis_tvalid = 0; s_axis_tlast = 0;
        sample_en = 0; start = 0; stop = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_d1", 32'(dac_data_1), 32'(IDLE_V));
        chk("reset_d2", 32'(dac_data_2), 32'(IDLE_V));
        chk("reset_tready", 32'(s_axis_tready), 32'd0);
        chk("reset_words", words_played, 32'd0);
        reset_n = 1;
        check();
        repeat (2) tick();

        // 8-word frame filled by count, strobe every 4 cycles
        run_frame(8, 100, -1, -1, -1, 0, -1, 1);
        chk("f8_count", 32'(got.size()), 32'd8);
        if (got.size() == 8) begin
            chk("f8_first", got[0], {16'h0101 ^ FLIP, 16'h0001 ^ FLIP});
            chk("f8_last", got[7], {16'h0108 ^ FLIP, 16'h0008 ^ FLIP});
        end
        chk("f8_done", 32'(fd_cnt), 32'd1);
        chk("f8_words", words_played, 32'd8);

        // 3-word frame shorter than prefill: PLAY entered on the tlast write
        run_frame(3, 100, -1, -1, -1, 0, -1, 1);
        chk("f3_count", 32'(got.size()), 32'd3);
        chk("f3_underflow", 32'(underflow), 32'd0);

        // source stalls after 5 of 10 words while the strobe keeps running
        run_frame(10, 100, -1, -1, 5, 40, -1, 1);
        chk("uf_flag", 32'(underflow), 32'd1);
        chk("uf_count", 32'(got.size()), 32'd10);
        chk("uf_words", words_played, 32'd10);

        // stop after 20 of 64 beats, remainder flushed
        run_frame(64, 100, -1, 20, -1, 0, -1, 0);
        chk("stop_tready", 32'(s_axis_tready), 32'd0);
        chk("stop_playing", 32'(playing), 32'd0);

        // simultaneous start and stop in IDLE: stop wins
        start = 1; stop = 1;
        repeat (6) tick();
        chk("both_tready", 32'(s_axis_tready), 32'd0);
        chk("both_playing", 32'(playing), 32'd0);
        start = 0; stop = 0;
        repeat (4) tick();

        for (int k = 0; k < 40; k++) begin
            int len, sa, sf;
            len = 1 + int'($urandom_range(39));
            sa  = ($urandom_range(3) == 0) ? int'($urandom_range(len)) : -1;
            sf  = ($urandom_range(3) == 0) ? int'($urandom_range(len)) : -1;
            run_frame(len, 30 + int'($urandom_range(70)), 10 + int'($urandom_range(90)),
                      sa, sf, int'($urandom_range(30)), -1, 0);
        end

        // asynchronous reset in the middle of playback
        run_frame(12, 100, -1, -1, -1, 0, 6, 0);

        // all-ones sample pins the output coding
        run_frame(2, 100, -1, -1, -1, 0, -1, 2);
        chk("ffff_count", 32'(got.size()), 32'd2);
        if (got.size() > 0) chk("ffff_code", 32'(got[0][15:0]), 32'(EXP_FFFF));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
